// File: rtl/cpu_clk_pkg.sv
// Shared types and defaults for the CPU clock sequencer (cpu_clock_ctrl).
// State encodings are fixed: IDLE=00, RUN=01, STEP=10; 11 is unused.
package cpu_clk_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } cpu_state_e;

endpackage : cpu_clk_pkg

// File: rtl/tick_prescaler.sv
// Prescaler for the CPU tick: counts clk cycles and flags a tick when the
// count reaches the divide value. div is compared live, so lowering it ticks at once.
module tick_prescaler
  import cpu_clk_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] pre;

  assign tick = enable && (pre >= div);

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre <= '0;
    end else if (clear || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + DIV_W'(1);
    end
  end

endmodule : tick_prescaler

// File: rtl/cpu_clock_ctrl.sv
// Run/halt/single-step sequencer issuing the one-cycle CPU tick_en qualifier.
// Optional breakpoint on the retired-cycle count when CPU_CLK_BREAKPOINT_EN is defined.
module cpu_clock_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             clr_cnt,
  input  logic [DIV_W-1:0] div,
`ifdef CPU_CLK_BREAKPOINT_EN
  input  logic             bp_en,
  input  logic [CNT_W-1:0] bp_value,
  output logic             bp_hit,
`endif
  output logic             tick_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             busy
);

  cpu_state_e state_q;
  cpu_state_e state_d;
  logic       tick;
  logic       pre_clear;
  logic       bp_trip;

  assign state   = state_q;
  assign busy    = (state_q != IDLE);
  assign tick_en = tick;

  // Prescaler restarts on every state change and is held at zero while idle.
  assign pre_clear = (state_q == IDLE) || (state_d != state_q);

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (pre_clear),
    .enable  (busy),
    .div     (div),
    .tick    (tick)
  );

`ifdef CPU_CLK_BREAKPOINT_EN
  // Compare against the count this tick produces, not the current one.
  assign bp_trip = tick && (state_q == RUN) && bp_en &&
                   ((cycle_cnt + CNT_W'(1)) == bp_value);
`else
  assign bp_trip = 1'b0;
`endif

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start)     state_d = RUN;
        else if (step) state_d = STEP;
      end
      RUN: begin
        if (stop || bp_trip) state_d = IDLE;
      end
      STEP: begin
        if (stop)       state_d = IDLE;
        else if (start) state_d = RUN;
        else if (tick)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
    end else if (clr_cnt) begin
      cycle_cnt <= '0;
    end else if (tick) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

`ifdef CPU_CLK_BREAKPOINT_EN
  // Sticky flag; a new trip outranks a coincident clearing request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bp_hit <= 1'b0;
    end else if (bp_trip) begin
      bp_hit <= 1'b1;
    end else if (start || step) begin
      bp_hit <= 1'b0;
    end
  end
`endif

endmodule : cpu_clock_ctrl

// File: tb/tb_cpu_clock_ctrl.sv
// Directed self-checking bench for cpu_clock_ctrl (CNT_W=4 to exercise wrap).
// Breakpoint scenario is compiled in when CPU_CLK_BREAKPOINT_EN is defined.
module tb_cpu_clock_ctrl;

  localparam int DIV_W = 8;
  localparam int CNT_W = 4;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic             start   = 1'b0;
  logic             stop    = 1'b0;
  logic             step    = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [DIV_W-1:0] div     = '0;
  logic             tick_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic             busy;
`ifdef CPU_CLK_BREAKPOINT_EN
  logic             bp_en    = 1'b0;
  logic [CNT_W-1:0] bp_value = '0;
  logic             bp_hit;
`endif

  int n_cmp = 0;
  int n_err = 0;

  cpu_clock_ctrl #(
    .DIV_W (DIV_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .clr_cnt   (clr_cnt),
    .div       (div),
`ifdef CPU_CLK_BREAKPOINT_EN
    .bp_en     (bp_en),
    .bp_value  (bp_value),
    .bp_hit    (bp_hit),
`endif
    .tick_en   (tick_en),
    .state     (state),
    .cycle_cnt (cycle_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one edge; afterwards the bench observes the cycle that follows it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b want 00", state); end
      n_cmp++; if (tick_en !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", tick_en); end
      n_cmp++; if (cycle_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cycle_cnt); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    end
    reset_n = 1'b1;
    start   = 1'b0;
    cyc();
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL post_reset_state: got %b want 00", state); end
  endtask

  task automatic test_free_run();
    div   = 8'd3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin
        n_cmp++; if (state !== 2'b01) begin n_err++; $display("FAIL run_state: got %b want 01", state); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_busy: got %b want 1", busy); end
      end
      n_cmp++; if (tick_en !== ((k % 4) == 0)) begin n_err++; $display("FAIL run_tick c%0d: got %b want %b", k, tick_en, ((k % 4) == 0)); end
      n_cmp++; if (cycle_cnt !== CNT_W'((k - 1) / 4)) begin n_err++; $display("FAIL run_cnt c%0d: got %0d want %0d", k, cycle_cnt, (k - 1) / 4); end
      cyc();
    end
    n_cmp++; if (tick_en !== 1'b0) begin n_err++; $display("FAIL run_tick c13: got %b want 0", tick_en); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL stop_state: got %b want 00", state); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %b want 0", busy); end
    n_cmp++; if (cycle_cnt !== 4'd3) begin n_err++; $display("FAIL stop_cnt: got %0d want 3", cycle_cnt); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (tick_en !== 1'b0) begin n_err++; $display("FAIL stop_no_tick %0d: got %b want 0", i, tick_en); end
      cyc();
    end
  endtask

  task automatic test_step();
    div     = 8'd2;
    step    = 1'b1;
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    n_cmp++; if (state !== 2'b10) begin n_err++; $display("FAIL step_state c1: got %b want 10", state); end
    n_cmp++; if (tick_en !== 1'b0) begin n_err++; $display("FAIL step_tick c1: got %b want 0", tick_en); end
    n_cmp++; if (cycle_cnt !== 4'd0) begin n_err++; $display("FAIL step_clr: got %0d want 0", cycle_cnt); end
    cyc();
    step = 1'b0;
    n_cmp++; if (tick_en !== 1'b0) begin n_err++; $display("FAIL step_tick c2: got %b want 0", tick_en); end
    cyc();
    n_cmp++; if (tick_en !== 1'b1) begin n_err++; $display("FAIL step_tick c3: got %b want 1", tick_en); end
    n_cmp++; if (state !== 2'b10) begin n_err++; $display("FAIL step_state c3: got %b want 10", state); end
    cyc();
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL step_done_state: got %b want 00", state); end
    n_cmp++; if (cycle_cnt !== 4'd1) begin n_err++; $display("FAIL step_cnt: got %0d want 1", cycle_cnt); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (tick_en !== 1'b0 || state !== 2'b00) begin n_err++; $display("FAIL step_idle %0d: got tick %b state %b want 0/00", i, tick_en, state); end
      cyc();
    end
  endtask

  task automatic test_clr_coincident();
    div     = 8'd0;
    start   = 1'b1;
    clr_cnt = 1'b1;
    cyc();
    start   = 1'b0;
    clr_cnt = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_cmp++; if (tick_en !== 1'b1) begin n_err++; $display("FAIL div0_tick c%0d: got %b want 1", k, tick_en); end
      n_cmp++; if (cycle_cnt !== CNT_W'(k - 1)) begin n_err++; $display("FAIL div0_cnt c%0d: got %0d want %0d", k, cycle_cnt, k - 1); end
      if (k < 3) cyc();
    end
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    n_cmp++; if (cycle_cnt !== 4'd0) begin n_err++; $display("FAIL clr_beats_tick: got %0d want 0", cycle_cnt); end
    n_cmp++; if (tick_en !== 1'b1) begin n_err++; $display("FAIL div0_tick c4: got %b want 1", tick_en); end
    cyc();
    n_cmp++; if (cycle_cnt !== 4'd1) begin n_err++; $display("FAIL clr_resume: got %0d want 1", cycle_cnt); end
    stop = 1'b1;
    n_cmp++; if (tick_en !== 1'b1) begin n_err++; $display("FAIL stop_cycle_tick: got %b want 1", tick_en); end
    cyc();
    stop = 1'b0;
    n_cmp++; if (state !== 2'b00 || tick_en !== 1'b0) begin n_err++; $display("FAIL div0_stop: got state %b tick %b want 00/0", state, tick_en); end
    n_cmp++; if (cycle_cnt !== 4'd2) begin n_err++; $display("FAIL stop_tick_counted: got %0d want 2", cycle_cnt); end
  endtask

  task automatic test_wrap();
    div     = 8'd0;
    start   = 1'b1;
    clr_cnt = 1'b1;
    cyc();
    start   = 1'b0;
    clr_cnt = 1'b0;
    repeat (15) cyc();
    n_cmp++; if (cycle_cnt !== 4'd15) begin n_err++; $display("FAIL wrap_max: got %0d want 15", cycle_cnt); end
    cyc();
    n_cmp++; if (cycle_cnt !== 4'd0) begin n_err++; $display("FAIL wrap_zero: got %0d want 0", cycle_cnt); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_cmp++; if (cycle_cnt !== 4'd1) begin n_err++; $display("FAIL wrap_17: got %0d want 1", cycle_cnt); end
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL wrap_state: got %b want 00", state); end
  endtask

  task automatic test_div_lower();
    div   = 8'd5;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    n_cmp++; if (tick_en !== 1'b0) begin n_err++; $display("FAIL div_pre3: got %b want 0", tick_en); end
    div = 8'd1;
    #1;
    n_cmp++; if (tick_en !== 1'b1) begin n_err++; $display("FAIL div_lower_immediate: got %b want 1", tick_en); end
    cyc();
    n_cmp++; if (tick_en !== 1'b0) begin n_err++; $display("FAIL div_lower_next: got %b want 0", tick_en); end
    cyc();
    n_cmp++; if (tick_en !== 1'b1) begin n_err++; $display("FAIL div_lower_resume: got %b want 1", tick_en); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_priority();
    div   = 8'd20;
    start = 1'b1;
    step  = 1'b1;
    cyc();
    start = 1'b0;
    step  = 1'b0;
    n_cmp++; if (state !== 2'b01) begin n_err++; $display("FAIL start_over_step: got %b want 01", state); end
    step = 1'b1;
    cyc();
    step = 1'b0;
    n_cmp++; if (state !== 2'b01) begin n_err++; $display("FAIL step_in_run: got %b want 01", state); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL run_stop: got %b want 00", state); end
    step = 1'b1;
    cyc();
    step = 1'b0;
    stop  = 1'b1;
    start = 1'b1;
    cyc();
    stop  = 1'b0;
    start = 1'b0;
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL stop_over_start: got %b want 00", state); end
    step = 1'b1;
    cyc();
    step  = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_cmp++; if (state !== 2'b01) begin n_err++; $display("FAIL step_to_run: got %b want 01", state); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    div   = 8'd2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    n_cmp++; if (state !== 2'b00 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_state: got %b busy %b want 00/0", state, busy); end
    n_cmp++; if (tick_en !== 1'b0) begin n_err++; $display("FAIL midrst_tick: got %b want 0", tick_en); end
    n_cmp++; if (cycle_cnt !== 4'd0) begin n_err++; $display("FAIL midrst_cnt: got %0d want 0", cycle_cnt); end
    cyc();
    n_cmp++; if (tick_en !== 1'b0) begin n_err++; $display("FAIL midrst_aborted: got %b want 0", tick_en); end
  endtask

`ifdef CPU_CLK_BREAKPOINT_EN
  task automatic test_breakpoint();
    int ticks;
    ticks    = 0;
    bp_en    = 1'b1;
    bp_value = 4'd5;
    div      = 8'd0;
    start    = 1'b1;
    clr_cnt  = 1'b1;
    cyc();
    start   = 1'b0;
    clr_cnt = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (tick_en === 1'b1) ticks++;
      cyc();
    end
    n_cmp++; if (ticks != 5) begin n_err++; $display("FAIL bp_ticks: got %0d want 5", ticks); end
    n_cmp++; if (bp_hit !== 1'b1) begin n_err++; $display("FAIL bp_hit_set: got %b want 1", bp_hit); end
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL bp_state: got %b want 00", state); end
    n_cmp++; if (cycle_cnt !== 4'd5) begin n_err++; $display("FAIL bp_cnt: got %0d want 5", cycle_cnt); end
    step = 1'b1;
    cyc();
    step = 1'b0;
    n_cmp++; if (bp_hit !== 1'b0) begin n_err++; $display("FAIL bp_hit_clear: got %b want 0", bp_hit); end
    n_cmp++; if (state !== 2'b10 || tick_en !== 1'b1) begin n_err++; $display("FAIL bp_step: got %b tick %b want 10/1", state, tick_en); end
    cyc();
    n_cmp++; if (state !== 2'b00 || cycle_cnt !== 4'd6) begin n_err++; $display("FAIL bp_step_done: got %b cnt %0d want 00/6", state, cycle_cnt); end
    bp_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_step();
    test_clr_coincident();
    test_wrap();
    test_div_lower();
    test_priority();
    test_reset_mid_run();
`ifdef CPU_CLK_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cpu_clock_ctrl

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Run/halt/single-step sequencer for the processor clock. Every CPU state element already sits on `clk`. This block issues a one-cycle `tick_en` qualifier that gates all architectural updates, so the CPU advances only when told to. It sits between the top-level `clk` source and the single-cycle datapath, and it exposes a retired-cycle counter for debug.

## Interface
- DIV_W, default 8: width of the prescaler divide value.
- CNT_W, default 16: width of the CPU cycle counter.
- `clk` input, 1 bit: system clock; all logic rises on posedge.
- `reset_n` input, 1 bit: synchronous, active-low reset.
- `start` input, 1 bit: pulse; enter free-run.
- `stop` input, 1 bit: pulse; return to idle.
- `step` input, 1 bit: pulse; issue exactly one tick.
- `clr_cnt` input, 1 bit: pulse; clear `cycle_cnt`.
- `div` input, DIV_W bits: tick period is div+1 `clk` cycles; sampled every cycle.
- `tick_en` output, 1 bit: CPU clock-enable, one `clk` wide.
- `state` output, 2 bits: current state encoding.
- `cycle_cnt` output, CNT_W bits: number of ticks issued.
- `busy` output, 1 bit: high when `state` is not IDLE.
- Clocking is decided: one clock; reset is synchronous and active-low.

## Operation
- States and encodings:
  - IDLE = 2'b00
  - RUN = 2'b01
  - STEP = 2'b10
  - 2'b11 is unused and recovers to IDLE.
- Prescaler register `pre` (DIV_W bits):
  - Cleared on every state entry and whenever the state is IDLE.
  - `tick_en = (state != IDLE) && (pre >= div)`; combinational from registers only.
  - On a tick, `pre` goes to 0; otherwise it increments.
  - Lowering `div` below `pre` causes an immediate tick, then normal counting resumes.
- Transitions out of IDLE:
  - `start` goes to RUN.
  - Otherwise `step` goes to STEP.
  - `start` has priority over `step`.
- Transitions out of RUN:
  - `stop` goes to IDLE.
  - Breakpoint hit goes to IDLE (see Configuration).
- Transitions out of STEP:
  - After its tick, goes to IDLE.
  - `stop` goes to IDLE.
  - `start` goes to RUN; `stop` has priority over `start`.
- Requests that are ignored:
  - `start` while in RUN.
  - `step` while in RUN or STEP.
- Stop behaviour: `stop` takes effect next cycle. A tick due in the same cycle as `stop` is still issued.
- Cycle counter:
  - `cycle_cnt` increments on each tick and wraps from 2^CNT_W-1 to 0.
  - `clr_cnt` beats a coincident tick: the result is 0.
- Reset (`reset_n`=0 at posedge):
  - state=IDLE, pre=0, cycle_cnt=0.
  - `tick_en`=0 and `busy`=0 in the following cycle.
  - Reset mid-run aborts any pending tick.

## Timing
- `start` or `step` sampled at edge N:
  - `busy`=1 from N+1.
  - First `tick_en` in cycle N+1+div.
- RUN: ticks follow every div+1 cycles after the first. With div=0, `tick_en` is continuously high.
- STEP: exactly one tick in cycle N+1+div; state=IDLE from N+2+div.
- `stop` sampled at edge M: `tick_en`=0 and state=IDLE from M+1.
- `cycle_cnt` updates on the edge that ends the tick cycle.

## Configuration
- Macro `CPU_CLK_BREAKPOINT_EN`.
- When defined, the block adds:
  - Inputs `bp_en` (1 bit) and `bp_value` (CNT_W bits).
  - Output `bp_hit` (1 bit, sticky, reset 0).
- Breakpoint rule (macro defined):
  - A tick in RUN that makes the post-increment count equal `bp_value`, with `bp_en`=1, sets `bp_hit`.
  - The same tick forces IDLE next cycle; that tick itself is issued.
  - `start` or `step` clears `bp_hit`.
  - STEP ignores the breakpoint.
- When undefined: these ports and `bp_hit` are absent, and RUN leaves only on `stop` or reset.

## Structure
- Shared package `cpu_clk_pkg` holds:
  - The state typedef and encodings (IDLE/RUN/STEP).
  - Defaults for DIV_W and CNT_W.
- Sub-module `tick_prescaler` (ports: `clk`, `reset_n`, `clear`, `enable`, `div`, `tick`) holds the `pre` counter and the compare.
- The FSM, the cycle counter and the breakpoint logic live in `cpu_clock_ctrl`.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles while driving `start`=1 → state=00, `tick_en`=0, `cycle_cnt`=0, `busy`=0.
- Free run, div=3: pulse `start` at edge 10 → ticks in cycles 14, 18, 22; pulse `stop` at edge 23 → no further ticks; `cycle_cnt`=3.
- Single step, div=2: pulse `step` → exactly one tick 3 cycles later, then state=00 and `cycle_cnt`=1; a second `step` during STEP is ignored.
- div=0 run with `clr_cnt` coincident with a tick: `tick_en` is solid high and the counter reads 0 on the next cycle.
- Wrap, CNT_W=4: run div=0 for 17 ticks → `cycle_cnt`=1.
- Breakpoint (macro defined): bp_en=1, bp_value=5, div=0, `start` → exactly 5 ticks, `bp_hit`=1, state=00; `step` clears `bp_hit`.
